// File: rtl/epoch_error_reporter_if.sv
// ---------------------------------------------------------------------------
// epoch_error_reporter_if
//   Sample stream into the epoch error reporter. The producer (master) offers
//   a (y_pred, y_target) pair with sample_valid; the reporter (slave) takes it
//   on any clock edge where sample_valid and sample_ready are both high.
//
//   sample_valid  master -> slave  pair valid this cycle
//   sample_ready  slave  -> master reporter can take a sample this cycle
//   y_pred        master -> slave  network output, signed DATA_W
//   y_target      master -> slave  expected output, signed DATA_W
// ---------------------------------------------------------------------------
interface epoch_error_reporter_if #(
  parameter int DATA_W = 16
) ();

  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] y_pred;
  logic [DATA_W-1:0] y_target;

  modport master (
    output sample_valid,
    output y_pred,
    output y_target,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  y_pred,
    input  y_target,
    output sample_ready
  );

endinterface : epoch_error_reporter_if

// File: rtl/epoch_error_reporter.sv
// ---------------------------------------------------------------------------
// epoch_error_reporter
//   Computes the squared error (y_pred - y_target)^2 of every accepted sample,
//   accumulates 2**LOG2_N of them per epoch and reports the truncated mean on
//   SQUARED_ERROR together with a one-cycle training_mode strobe. The
//   training-control FSM answers one cycle after the strobe on training_done;
//   epochs repeat until training_done or until MAX_EPOCHS epochs have been
//   reported, in which case the sticky timeout flag is raised.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   start             pulse in IDLE or DONE: begin epoch 1
//   smp               sample stream (slave side of epoch_error_reporter_if)
//   training_done     convergence reached (from training FSM)
//   adam_signal       Adam optimiser selected (from training FSM)
//   manhatten_signal  Manhattan optimiser selected (from training FSM)
//   training_mode     one-cycle strobe, SQUARED_ERROR valid
//   SQUARED_ERROR     epoch mean squared error, unsigned, 34 bits
//   epoch_count       completed epochs, saturates at 255
//   opt_sel           01 Adam, 10 Manhattan, 00 none; both high keeps old
//   busy              high in every state except IDLE and DONE
//   timeout           sticky: MAX_EPOCHS reached without training_done
// ---------------------------------------------------------------------------
module epoch_error_reporter #(
  parameter int DATA_W     = 16,
  parameter int LOG2_N     = 4,
  parameter int MAX_EPOCHS = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  epoch_error_reporter_if.slave    smp,
  input  logic                     training_done,
  input  logic                     adam_signal,
  input  logic                     manhatten_signal,
  output logic                     training_mode,
  output logic [33:0]              SQUARED_ERROR,
  output logic [7:0]               epoch_count,
  output logic [1:0]               opt_sel,
  output logic                     busy,
  output logic                     timeout
);

  localparam int DIFF_W = DATA_W + 1;        // y_pred - y_target, signed
  localparam int SQ_W   = 2 * DATA_W + 1;    // diff^2, unsigned
  localparam int ACC_W  = SQ_W + LOG2_N;     // sum of 2**LOG2_N squares
  localparam int MEAN_W = ACC_W - LOG2_N;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_REPORT,
    S_WAIT_FSM,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_phase;      // second cycle of DRAIN / WAIT_FSM
  logic [LOG2_N-1:0]   r_cnt;        // samples accepted this epoch
  logic                r_v1;
  logic [DIFF_W-1:0]   r_diff;
  logic                r_v2;
  logic [SQ_W-1:0]     r_sq;
  logic [ACC_W-1:0]    r_acc;
  logic                r_tmode;
  logic [33:0]         r_sq_err;
  logic [7:0]          r_epoch;
  logic [1:0]          r_opt;
  logic                r_timeout;

  logic                w_accept;
  logic [DIFF_W-1:0]   w_diff;
  logic [SQ_W-1:0]     w_diff_ext;
  logic [SQ_W-1:0]     w_sq;
  logic [MEAN_W-1:0]   w_mean;

  assign w_accept = smp.sample_valid && (r_state == S_ACCUM);

  // Sign-extend both operands by one bit so the difference cannot wrap.
  assign w_diff = {smp.y_pred[DATA_W-1], smp.y_pred}
                - {smp.y_target[DATA_W-1], smp.y_target};

  // The square of a DIFF_W-bit signed value always fits in SQ_W unsigned
  // bits, so a modulo-2**SQ_W multiply of the sign-extended diff is exact.
  assign w_diff_ext = {{(SQ_W - DIFF_W){r_diff[DIFF_W-1]}}, r_diff};
  assign w_sq       = w_diff_ext * w_diff_ext;

  assign w_mean = r_acc[ACC_W-1:LOG2_N];

  // NOTE: every register in this block uses non-blocking assignment so all
  // of them update from the same pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    // NOTE: the reset branch clears every register, pipeline data included,
    // so nothing from an aborted epoch can leak into the next one.
    if (rst) begin
      r_state   <= S_IDLE;
      r_phase   <= 1'b0;
      r_cnt     <= '0;
      r_v1      <= 1'b0;
      r_diff    <= '0;
      r_v2      <= 1'b0;
      r_sq      <= '0;
      r_acc     <= '0;
      r_tmode   <= 1'b0;
      r_sq_err  <= '0;
      r_epoch   <= '0;
      r_opt     <= 2'b00;
      r_timeout <= 1'b0;
    end else begin
      // Three-stage datapath: S1 difference, S2 square, S3 accumulate.
      r_v1 <= w_accept;
      if (w_accept) r_diff <= w_diff;
      r_v2 <= r_v1;
      if (r_v1) r_sq <= w_sq;
      if (r_v2) r_acc <= r_acc + ACC_W'(r_sq);

      // Optimiser tracking; both selects high is treated as a glitch.
      if (adam_signal && !manhatten_signal)      r_opt <= 2'b01;
      else if (manhatten_signal && !adam_signal) r_opt <= 2'b10;
      else if (!adam_signal && !manhatten_signal) r_opt <= 2'b00;

      r_tmode <= 1'b0;

      // Clearing r_acc below overrides the S3 update above; the pipeline is
      // always empty in the states that clear it.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end

        S_ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + LOG2_N'(1);
            if (&r_cnt) begin
              r_state <= S_DRAIN;
              r_phase <= 1'b0;
            end
          end
        end

        // Two cycles for the last sample to leave S2 and S3.
        S_DRAIN: begin
          r_phase <= 1'b1;
          if (r_phase) r_state <= S_REPORT;
        end

        S_REPORT: begin
          r_sq_err <= 34'(w_mean);
          r_tmode  <= 1'b1;
          if (r_epoch != 8'hFF) r_epoch <= r_epoch + 8'd1;
          r_state  <= S_WAIT_FSM;
          r_phase  <= 1'b0;
        end

        // First cycle: strobe is visible to the training FSM. Second cycle:
        // its answer on training_done is sampled.
        S_WAIT_FSM: begin
          r_phase <= 1'b1;
          if (r_phase) begin
            if (training_done) begin
              r_state <= S_DONE;
            end else if (r_epoch == 8'(MAX_EPOCHS)) begin
              r_timeout <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_ACCUM;
              r_acc   <= '0;
              r_cnt   <= '0;
            end
          end
        end

        S_DONE: begin
          if (start) begin
            r_state   <= S_ACCUM;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_epoch   <= '0;
            r_timeout <= 1'b0;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pure decodes of the state register, so these are glitch-free.
  assign smp.sample_ready = (r_state == S_ACCUM);
  assign busy             = (r_state != S_IDLE) && (r_state != S_DONE);

  assign training_mode = r_tmode;
  assign SQUARED_ERROR = r_sq_err;
  assign epoch_count   = r_epoch;
  assign opt_sel       = r_opt;
  assign timeout       = r_timeout;

endmodule : epoch_error_reporter

// File: tb/tb_epoch_error_reporter.sv
// ---------------------------------------------------------------------------
// tb_epoch_error_reporter
//   Directed stimulus for epoch_error_reporter. Each epoch's expected report
//   is queued when the stimulus is issued; a monitor pops it on every
//   training_mode strobe. A small responder plays the training FSM, answering
//   each strobe one cycle later with a queued training_done value.
// ---------------------------------------------------------------------------
module tb_epoch_error_reporter;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 4;
  localparam int N      = 1 << LOG2_N;
  localparam int MAXE   = 2;

  typedef struct {
    logic [33:0] sq;
    logic [7:0]  ep;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        training_done = 1'b0;
  logic        adam_signal;
  logic        manhatten_signal;
  logic        training_mode;
  logic [33:0] SQUARED_ERROR;
  logic [7:0]  epoch_count;
  logic [1:0]  opt_sel;
  logic        busy;
  logic        timeout;

  epoch_error_reporter_if #(.DATA_W(DATA_W)) smp_if ();

  epoch_error_reporter #(
    .DATA_W    (DATA_W),
    .LOG2_N    (LOG2_N),
    .MAX_EPOCHS(MAXE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .smp             (smp_if.slave),
    .training_done   (training_done),
    .adam_signal     (adam_signal),
    .manhatten_signal(manhatten_signal),
    .training_mode   (training_mode),
    .SQUARED_ERROR   (SQUARED_ERROR),
    .epoch_count     (epoch_count),
    .opt_sel         (opt_sel),
    .busy            (busy),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t sb_q[$];
  bit   done_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          acc_n        = 0;
  int          last_acc_cyc = 0;
  logic [33:0] last_sq      = '0;
  logic        prev_tm      = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      acc_n   = 0;
      last_sq = '0;
      prev_tm = 1'b0;
    end else begin
      if (smp_if.sample_valid && smp_if.sample_ready) begin
        acc_n++;
        last_acc_cyc = cyc + 1;  // accepted on the coming edge
      end
      if (training_mode) begin
        check("strobe_width", 64'(prev_tm), 64'd0);
        check("accepts_per_epoch", 64'(acc_n), 64'(N));
        check("strobe_latency", 64'(cyc - last_acc_cyc), 64'd3);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: got strobe with SQUARED_ERROR=%0d expected none", SQUARED_ERROR);
        end else begin
          e = sb_q.pop_front();
          check("squared_error", 64'(SQUARED_ERROR), 64'(e.sq));
          check("report_epoch_count", 64'(epoch_count), 64'(e.ep));
        end
        acc_n   = 0;
        last_sq = SQUARED_ERROR;
      end else if (SQUARED_ERROR !== last_sq) begin
        n_checks++;
        n_errors++;
        $display("FAIL sq_stable: got %0d expected %0d", SQUARED_ERROR, last_sq);
        last_sq = SQUARED_ERROR;
      end
      prev_tm = training_mode;
    end
  end

  // ---------------- training FSM responder ----------------
  always @(negedge clk) begin : responder
    bit r;
    if (!rst && training_mode) begin
      r = (done_q.size() != 0) ? done_q.pop_front() : 1'b0;
      @(posedge clk); #1 training_done = r;
      @(posedge clk); #1 training_done = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic expect_epoch(input logic [33:0] sq, input logic [7:0] ep, input bit done);
    exp_t e;
    e.sq = sq;
    e.ep = ep;
    sb_q.push_back(e);
    done_q.push_back(done);
  endtask

  // Offer n samples; gappy drives valid every other cycle. Only real
  // handshakes count towards n.
  task automatic send(input int pred, input int tgt, input int n, input bit gappy);
    int sent  = 0;
    int guard = 0;
    bit took;
    smp_if.y_pred   = DATA_W'(pred);
    smp_if.y_target = DATA_W'(tgt);
    while (sent < n) begin
      if (guard >= 4 * n + 40) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got %0d accepts expected %0d", sent, n);
        break;
      end
      smp_if.sample_valid = gappy ? (guard % 2 == 1) : 1'b1;
      @(negedge clk);
      took = smp_if.sample_valid && smp_if.sample_ready;
      @(posedge clk); #1;
      if (took) sent++;
      guard++;
    end
    smp_if.sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    @(negedge clk);
    while (busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : stim
    rst                 = 1'b0;
    start               = 1'b0;
    adam_signal         = 1'b0;
    manhatten_signal    = 1'b0;
    smp_if.sample_valid = 1'b0;
    smp_if.y_pred       = '0;
    smp_if.y_target     = '0;

    // Reset state
    do_reset();
    check("rst_training_mode", 64'(training_mode), 64'd0);
    check("rst_squared_error", 64'(SQUARED_ERROR), 64'd0);
    check("rst_epoch_count", 64'(epoch_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_opt_sel", 64'(opt_sel), 64'd0);
    check("rst_sample_ready", 64'(smp_if.sample_ready), 64'd0);

    // Optimiser select tracking
    adam_signal = 1'b1;
    @(posedge clk); #1 check("opt_adam", 64'(opt_sel), 64'd1);
    adam_signal = 1'b0; manhatten_signal = 1'b1;
    @(posedge clk); #1 check("opt_manhattan", 64'(opt_sel), 64'd2);
    adam_signal = 1'b1;
    @(posedge clk); #1 check("opt_both_keeps", 64'(opt_sel), 64'd2);
    manhatten_signal = 1'b0;
    @(posedge clk); #1 check("opt_back_to_adam", 64'(opt_sel), 64'd1);
    adam_signal = 1'b0;

    // 1: constant error 3 -> mean 9
    pulse_start();
    check("start_busy", 64'(busy), 64'd1);
    expect_epoch(34'd9, 8'd1, 1'b1);
    send(3, 0, N, 1'b0);
    wait_idle("t1_done_busy");
    check("t1_squared_error", 64'(SQUARED_ERROR), 64'd9);
    check("t1_epoch_count", 64'(epoch_count), 64'd1);

    // 2: extreme operands, diff = -65535
    pulse_start();
    check("restart_epoch_clear", 64'(epoch_count), 64'd0);
    expect_epoch(34'd4294836225, 8'd1, 1'b1);
    send(-32768, 32767, N, 1'b0);
    wait_idle("t2_done_busy");
    check("t2_squared_error", 64'(SQUARED_ERROR), 64'd4294836225);

    // 3: two epochs, start pulsed mid-epoch must be ignored
    pulse_start();
    expect_epoch(34'd16, 8'd1, 1'b0);
    expect_epoch(34'd0, 8'd2, 1'b1);
    send(5, 1, N / 2, 1'b0);
    pulse_start();
    send(5, 1, N / 2, 1'b0);
    send(7, 7, N, 1'b0);
    wait_idle("t3_done_busy");
    check("t3_epoch_count", 64'(epoch_count), 64'd2);
    check("t3_no_timeout", 64'(timeout), 64'd0);
    check("t3_squared_error", 64'(SQUARED_ERROR), 64'd0);

    // 4: 50% valid, kept toggling while sample_ready is low
    pulse_start();
    expect_epoch(34'd4, 8'd1, 1'b0);
    expect_epoch(34'd4, 8'd2, 1'b1);
    send(1, -1, 2 * N, 1'b1);
    repeat (8) begin
      smp_if.sample_valid = ~smp_if.sample_valid;
      @(posedge clk); #1;
    end
    smp_if.sample_valid = 1'b0;
    wait_idle("t4_done_busy");
    check("t4_epoch_count", 64'(epoch_count), 64'd2);

    // 5: training_done never comes -> timeout at MAX_EPOCHS; sum 151 -> 9
    pulse_start();
    expect_epoch(34'd9, 8'd1, 1'b0);
    expect_epoch(34'd9, 8'd2, 1'b0);
    send(0, 3, N - 1, 1'b0);
    send(0, 4, 1, 1'b0);
    send(0, 3, N - 1, 1'b0);
    send(0, 4, 1, 1'b0);
    wait_idle("t5_done_busy");
    check("t5_timeout", 64'(timeout), 64'd1);
    check("t5_epoch_count", 64'(epoch_count), 64'd2);

    // 6: reset mid-epoch, then a clean epoch of error 2
    pulse_start();
    send(9, 0, 7, 1'b0);
    do_reset();
    check("t6_rst_squared_error", 64'(SQUARED_ERROR), 64'd0);
    check("t6_rst_epoch_count", 64'(epoch_count), 64'd0);
    check("t6_rst_timeout", 64'(timeout), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    pulse_start();
    expect_epoch(34'd4, 8'd1, 1'b1);
    send(-1, 1, N, 1'b0);
    wait_idle("t6_done_busy");
    check("t6_squared_error", 64'(SQUARED_ERROR), 64'd4);

    repeat (4) @(posedge clk);
    check("reports_outstanding", 64'(sb_q.size()), 64'd0);
    check("fsm_answers_outstanding", 64'(done_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_epoch_error_reporter
